// File: rtl/pll_reset_sequencer.sv
// rtl/pll_reset_sequencer.sv - PLL reset pulse, lock wait with bounded retries, debounced core reset release
module pll_reset_sequencer #(
  parameter int SYNC_STAGES    = 2,
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 500000,
  parameter int STABLE_CYCLES  = 1024,
  parameter int MAX_RETRIES    = 3
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       locked,
  input  logic       relock_req,
  output logic       pll_rst,
  output logic       core_reset,
  output logic       ready,
  output logic       fault,
  output logic [3:0] retry_count
);

  localparam int CNT_MAX_A = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
  localparam int CNT_MAX   = (CNT_MAX_A > STABLE_CYCLES) ? CNT_MAX_A : STABLE_CYCLES;
  localparam int CW        = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CW-1:0] RST_LAST     = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STABLE_LAST  = CW'(STABLE_CYCLES - 1);
  localparam logic [3:0]    RETRY_LIMIT  = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_PLL_RESET,
    S_WAIT_LOCK,
    S_STABLE,
    S_RUN,
    S_FAULT
  } state_t;

  state_t                 r_state;
  state_t                 w_next_state;
  logic [CW-1:0]          r_cnt;
  logic [CW-1:0]          w_next_cnt;
  logic [3:0]             r_retry;
  logic [3:0]             w_next_retry;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_lock_s;
  logic                   r_pll_rst;
  logic                   r_core_reset;
  logic                   r_ready;
  logic                   r_fault;

  assign w_lock_s = r_sync[SYNC_STAGES-1];

  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt + CW'(1);
    w_next_retry = r_retry;
    if (relock_req) begin
      w_next_state = S_PLL_RESET;
      w_next_cnt   = '0;
      w_next_retry = '0;
    end else begin
      case (r_state)
        S_PLL_RESET: begin
          if (r_cnt == RST_LAST) begin
            w_next_state = S_WAIT_LOCK;
            w_next_cnt   = '0;
          end
        end
        S_WAIT_LOCK: begin
          // A lock seen on the timeout cycle still wins over the retry.
          if (w_lock_s) begin
            w_next_state = S_STABLE;
            w_next_cnt   = '0;
          end else if (r_cnt == TIMEOUT_LAST) begin
            w_next_cnt = '0;
            if (r_retry < RETRY_LIMIT) begin
              w_next_state = S_PLL_RESET;
              if (r_retry != 4'hF) w_next_retry = r_retry + 4'd1;
            end else begin
              w_next_state = S_FAULT;
            end
          end
        end
        S_STABLE: begin
          if (!w_lock_s) begin
            w_next_state = S_WAIT_LOCK;
            w_next_cnt   = '0;
          end else if (r_cnt == STABLE_LAST) begin
            w_next_state = S_RUN;
            w_next_cnt   = '0;
          end
        end
        S_RUN: begin
          w_next_cnt = '0;
          if (!w_lock_s) begin
            w_next_state = S_PLL_RESET;
            w_next_retry = '0;
          end
        end
        S_FAULT: begin
          w_next_cnt = '0;
        end
        default: begin
          w_next_state = S_PLL_RESET;
          w_next_cnt   = '0;
        end
      endcase
    end
  end

  // Outputs decode the next state so they switch on the same edge as the state.
  always_ff @(posedge refclk) begin
    if (rst) begin
      r_state      <= S_PLL_RESET;
      r_cnt        <= '0;
      r_retry      <= '0;
      r_sync       <= '0;
      r_pll_rst    <= 1'b1;
      r_core_reset <= 1'b1;
      r_ready      <= 1'b0;
      r_fault      <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_cnt        <= w_next_cnt;
      r_retry      <= w_next_retry;
      r_sync       <= {r_sync[SYNC_STAGES-2:0], locked};
      r_pll_rst    <= (w_next_state == S_PLL_RESET);
      r_core_reset <= (w_next_state != S_RUN);
      r_ready      <= (w_next_state == S_RUN);
      r_fault      <= (w_next_state == S_FAULT);
    end
  end

  assign pll_rst     = r_pll_rst;
  assign core_reset  = r_core_reset;
  assign ready       = r_ready;
  assign fault       = r_fault;
  assign retry_count = r_retry;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb/tb_pll_reset_sequencer.sv - table-driven scoreboard bench for pll_reset_sequencer
module tb_pll_reset_sequencer;

  logic       refclk = 1'b0;
  logic       rst = 1'b1;
  logic       locked = 1'b0;
  logic       relock_req = 1'b0;
  logic       pll_rst;
  logic       core_reset;
  logic       ready;
  logic       fault;
  logic [3:0] retry_count;

  pll_reset_sequencer #(
    .SYNC_STAGES   (2),
    .PLL_RST_CYCLES(4),
    .LOCK_TIMEOUT  (20),
    .STABLE_CYCLES (8),
    .MAX_RETRIES   (2)
  ) dut (
    .refclk     (refclk),
    .rst        (rst),
    .locked     (locked),
    .relock_req (relock_req),
    .pll_rst    (pll_rst),
    .core_reset (core_reset),
    .ready      (ready),
    .fault      (fault),
    .retry_count(retry_count)
  );

  always #10 refclk = ~refclk;

  typedef struct packed {
    logic       pll;
    logic       core;
    logic       rdy;
    logic       flt;
    logic [3:0] retry;
  } exp_t;

  typedef struct {
    string name;
    int    n;
    logic  rst;
    logic  locked;
    logic  relock;
    exp_t  exp;
  } vec_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   total = 0;
  int   bad = 0;

  task automatic add(input string name, input int n, input logic r, input logic l, input logic rq,
                     input logic p, input logic c, input logic rd, input logic f, input logic [3:0] rc);
    vec_t v;
    v.name = name; v.n = n; v.rst = r; v.locked = l; v.relock = rq;
    v.exp = '{pll: p, core: c, rdy: rd, flt: f, retry: rc};
    tbl.push_back(v);
  endtask

  task automatic check_int(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  initial begin
    exp_t e;
    exp_t a;
    int   step;
    int   cyc;
    int   n_pll;

    //  name               n  rst lk rq   pll core rdy flt retry
    add("reset",           3, 1, 0, 0,   1, 1, 0, 0, 0);
    add("t1_pllrst",       3, 0, 0, 0,   1, 1, 0, 0, 0);
    add("t1_wait",        10, 0, 0, 0,   0, 1, 0, 0, 0);
    add("t1_stable",      10, 0, 1, 0,   0, 1, 0, 0, 0);
    add("t1_run",          4, 0, 1, 0,   0, 0, 1, 0, 0);
    add("t4_sync",         2, 0, 0, 0,   0, 0, 1, 0, 0);
    add("t4_pulse",        4, 0, 0, 0,   1, 1, 0, 0, 0);
    add("t2_wait0",       20, 0, 0, 0,   0, 1, 0, 0, 0);
    add("t2_pulse1",       4, 0, 0, 0,   1, 1, 0, 0, 1);
    add("t2_wait1",       20, 0, 0, 0,   0, 1, 0, 0, 1);
    add("t2_pulse2",       4, 0, 0, 0,   1, 1, 0, 0, 2);
    add("t2_wait2",       20, 0, 0, 0,   0, 1, 0, 0, 2);
    add("t2_fault",        5, 0, 0, 0,   0, 1, 0, 1, 2);
    add("t5_relock_fault", 1, 0, 0, 1,   1, 1, 0, 0, 0);
    add("t5_pllrst",       3, 0, 0, 0,   1, 1, 0, 0, 0);
    add("t5_lock",        10, 0, 1, 0,   0, 1, 0, 0, 0);
    add("t5_run",          3, 0, 1, 0,   0, 0, 1, 0, 0);
    add("t3_relock_run",   1, 0, 1, 1,   1, 1, 0, 0, 0);
    add("t3_pllrst",       3, 0, 1, 0,   1, 1, 0, 0, 0);
    add("t3_pre",          5, 0, 1, 0,   0, 1, 0, 0, 0);
    add("t3_glitch",       3, 0, 0, 0,   0, 1, 0, 0, 0);
    add("t3_restable",    10, 0, 1, 0,   0, 1, 0, 0, 0);
    add("t3_run",          3, 0, 1, 0,   0, 0, 1, 0, 0);
    add("t6_rst_run",      1, 1, 1, 0,   1, 1, 0, 0, 0);
    add("t6_pllrst",       3, 0, 0, 0,   1, 1, 0, 0, 0);
    add("t6_wait",        20, 0, 0, 0,   0, 1, 0, 0, 0);
    add("t6_pulse",        4, 0, 0, 0,   1, 1, 0, 0, 1);
    add("t6_wait1",        5, 0, 0, 0,   0, 1, 0, 0, 1);
    add("t6_rst_wait",     1, 1, 0, 0,   1, 1, 0, 0, 0);
    add("tt_pllrst",       3, 0, 0, 0,   1, 1, 0, 0, 0);
    add("tt_wait",        18, 0, 0, 0,   0, 1, 0, 0, 0);
    add("tt_lock_timeout",10, 0, 1, 0,   0, 1, 0, 0, 0);
    add("tt_run",          3, 0, 1, 0,   0, 0, 1, 0, 0);

    step = 0;
    foreach (tbl[i]) begin
      for (int k = 0; k < tbl[i].n; k++) begin
        rst        = tbl[i].rst;
        locked     = tbl[i].locked;
        relock_req = tbl[i].relock;
        sb.push_back(tbl[i].exp);
        @(posedge refclk);
        #1;
        e = sb.pop_front();
        a = '{pll: pll_rst, core: core_reset, rdy: ready, flt: fault, retry: retry_count};
        total++;
        if (a !== e) begin
          bad++;
          $display("FAIL %s step=%0d got pll=%b core=%b rdy=%b flt=%b retry=%0d want pll=%b core=%b rdy=%b flt=%b retry=%0d",
                   tbl[i].name, step, a.pll, a.core, a.rdy, a.flt, a.retry,
                   e.pll, e.core, e.rdy, e.flt, e.retry);
        end
        step++;
      end
    end

    // Relock from RUN with lock held: count pulse width and cycles to ready.
    rst = 1'b0;
    locked = 1'b1;
    relock_req = 1'b1;
    @(posedge refclk);
    #1;
    relock_req = 1'b0;
    check_int("hs_relock_pll_rst", int'(pll_rst), 1);
    check_int("hs_relock_retry", int'(retry_count), 0);
    cyc = 1;
    n_pll = pll_rst ? 1 : 0;
    while (!ready && cyc < 100) begin
      @(posedge refclk);
      #1;
      cyc++;
      if (pll_rst) n_pll++;
    end
    check_int("hs_pulse_width", n_pll, 4);
    check_int("hs_ready_latency", cyc, 14);
    check_int("hs_core_reset_low", int'(core_reset), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
